// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings, baud table and divisor helpers
package uart_pkg;

  localparam int unsigned BAUD_RATES [16] = '{
    200, 300, 600, 1200, 1800, 2400, 4800, 9600,
    19200, 28800, 38400, 57600, 76800, 115200, 230400, 460800
  };

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b010,
    PARITY = 3'b011,
    STOP1  = 3'b100,
    STOP2  = 3'b101
  } tnsm_state_t;

  typedef enum logic [1:0] {
    FS_5 = 2'b00,
    FS_6 = 2'b01,
    FS_7 = 2'b10,
    FS_8 = 2'b11
  } frame_size_t;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'b00,
    PAR_EVEN  = 2'b01,
    PAR_ODD   = 2'b10,
    PAR_NONE3 = 2'b11
  } parity_t;

  function automatic int unsigned baud_div(input int unsigned clk_freq, input logic [3:0] sel);
    return clk_freq / BAUD_RATES[sel];
  endfunction

  // Keeps only the low 5..8 bits that belong to the configured frame.
  function automatic logic [7:0] frame_mask(input logic [1:0] fs);
    return 8'hFF >> (2'd3 - fs);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - divisor-load bit-period counter producing bit_tick
module uart_baud_tick #(
  parameter int CNT_W = 18
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             restart,
  input  logic             run,
  input  logic [CNT_W-1:0] div,
  output logic             bit_tick
);

  logic [CNT_W-1:0] cnt;

  assign bit_tick = run && (cnt == div - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!arst_n || restart || !run) begin
      cnt <= '0;
    end else if (bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_peer_tx.sv
// rtl/uart_peer_tx.sv - UART frame transmitter driving the rx pin of a peer uart_ip
module uart_peer_tx
  import uart_pkg::*;
#(
  parameter int   CLK_FREQ   = 50000000,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       enable,
  input  logic [3:0] baud_sel,
  input  logic [1:0] frame_size,
  input  logic [1:0] parity_type,
  input  logic       stop_type,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int CNT_W = $clog2(CLK_FREQ / 200);

  tnsm_state_t      state_q, state_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       data_q;
  logic [1:0]       fs_q;
  parity_t          par_q;
  logic             stop_q;
  logic [CNT_W-1:0] div_q;
  logic             done_q, done_d;
  logic             tx_q, tx_d;
  logic             bit_tick;
  logic             accept;
  logic [2:0]       last_idx;
  logic             has_par;
  logic             par_bit;

  assign tx_ready = (state_q == IDLE) && enable && !done_q && arst_n;
  assign accept   = tx_valid && tx_ready;
  assign busy     = (state_q != IDLE);
  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign last_idx = 3'd4 + {1'b0, fs_q};
  assign has_par  = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
  // data_q is stored already masked, so the reduction covers only sent bits.
  assign par_bit  = (par_q == PAR_ODD) ? ~^data_q : ^data_q;

  uart_baud_tick #(.CNT_W(CNT_W)) u_baud_tick (
    .clk      (clk),
    .arst_n   (arst_n),
    .restart  (accept),
    .run      (busy),
    .div      (div_q),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    done_d    = 1'b0;
    if (!enable) begin
      state_d   = IDLE;
      bit_idx_d = '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          state_d   = START;
          bit_idx_d = '0;
        end
        START: if (bit_tick) state_d = DATA;
        DATA: if (bit_tick) begin
          if (bit_idx_q == last_idx) begin
            state_d   = has_par ? PARITY : STOP1;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
        PARITY: if (bit_tick) state_d = STOP1;
        STOP1: if (bit_tick) begin
          if (stop_q) begin
            state_d = STOP2;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        STOP2: if (bit_tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // tx is registered from the next state so it changes on the same edge as the state.
  always_comb begin
    tx_d = IDLE_LEVEL;
    case (state_d)
      START:        tx_d = 1'b0;
      DATA:         tx_d = data_q[bit_idx_d];
      PARITY:       tx_d = par_bit;
      STOP1, STOP2: tx_d = 1'b1;
      default:      tx_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      data_q    <= '0;
      fs_q      <= '0;
      par_q     <= PAR_NONE;
      stop_q    <= 1'b0;
      div_q     <= '0;
      done_q    <= 1'b0;
      tx_q      <= IDLE_LEVEL;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      done_q    <= done_d;
      tx_q      <= tx_d;
      if (accept) begin
        data_q <= tx_data & frame_mask(frame_size);
        fs_q   <= frame_size;
        par_q  <= parity_t'(parity_type);
        stop_q <= stop_type;
        div_q  <= CNT_W'(baud_div(CLK_FREQ, baud_sel));
      end
    end
  end

endmodule

// File: tb/tb_uart_peer_tx.sv
// tb/tb_uart_peer_tx.sv - directed self-checking bench for uart_peer_tx
module tb_uart_peer_tx;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       enable;
  logic [3:0] baud_sel;
  logic [1:0] frame_size;
  logic [1:0] parity_type;
  logic       stop_type;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic       tx_done;

  int tests = 0;
  int fails = 0;

  uart_peer_tx dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .enable      (enable),
    .baud_sel    (baud_sel),
    .frame_size  (frame_size),
    .parity_type (parity_type),
    .stop_type   (stop_type),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx          (tx),
    .busy        (busy),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [3:0] sel, input logic [1:0] fs, input logic [1:0] par,
                         input logic stp, input logic [7:0] d);
    baud_sel = sel; frame_size = fs; parity_type = par; stop_type = stp; tx_data = d;
  endtask

  // exp holds the whole frame LSB-first: start bit, data, parity, stop bit(s).
  task automatic check_frame(input string tag, input logic [11:0] exp, input int nb, input int div,
                             input logic hold, input logic [7:0] next_data, output int lat);
    logic bad;
    lat = 0;
    while (tx !== 1'b0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_start"}, 32'(tx), 32'd0);
    if (tx !== 1'b0) return;
    if (hold) begin
      tx_data = next_data;
    end else begin
      tx_valid    = 1'b0;
      tx_data     = ~tx_data;
      baud_sel    = baud_sel + 4'd1;
      frame_size  = ~frame_size;
      parity_type = ~parity_type;
      stop_type   = ~stop_type;
    end
    for (int k = 0; k < nb; k++) begin
      bad = 1'b0;
      for (int c = 0; c < div; c++) begin
        if (tx !== exp[k] || busy !== 1'b1 || tx_done !== 1'b0 || tx_ready !== 1'b0) bad = 1'b1;
        @(negedge clk);
      end
      chk($sformatf("%s_bit%0d", tag, k), 32'(bad), 32'd0);
    end
    chk({tag, "_end"}, 32'({tx_done, busy, tx, tx_ready}), 32'b1010);
  endtask

  initial begin
    int   lat;
    int   t;
    logic bad;

    arst_n = 1'b0; enable = 1'b1; tx_valid = 1'b0;
    set_cfg(4'd7, 2'b11, 2'b00, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({tx, busy, tx_ready, tx_done}), 32'b1000);
    arst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'({tx, busy, tx_ready, tx_done}), 32'b1010);

    // 8N1 0xA5 at DIV=5208
    set_cfg(4'd7, 2'b11, 2'b00, 1'b0, 8'hA5);
    tx_valid = 1'b1;
    check_frame("8n1_a5", 12'h34A, 10, 5208, 1'b0, 8'h00, lat);
    chk("8n1_latency", 32'(lat), 32'd1);

    // 5E2 0xFF at DIV=108: 11111, parity 1, two stops
    @(negedge clk);
    set_cfg(4'd15, 2'b00, 2'b01, 1'b1, 8'hFF);
    tx_valid = 1'b1;
    check_frame("5e2_ff", 12'h1FE, 9, 108, 1'b0, 8'h00, lat);

    // 7O1 0x00 at DIV=434: parity 1
    @(negedge clk);
    set_cfg(4'd13, 2'b10, 2'b10, 1'b0, 8'h00);
    tx_valid = 1'b1;
    check_frame("7o1_00", 12'h300, 10, 434, 1'b0, 8'h00, lat);

    // back-to-back 0x55 then 0x0F with tx_valid held
    @(negedge clk);
    set_cfg(4'd15, 2'b11, 2'b00, 1'b0, 8'h55);
    tx_valid = 1'b1;
    check_frame("b2b_55", 12'h2AA, 10, 108, 1'b1, 8'h0F, lat);
    @(negedge clk);
    chk("b2b_gap", 32'({tx, busy, tx_ready, tx_done}), 32'b1010);
    check_frame("b2b_0f", 12'h21E, 10, 108, 1'b0, 8'h00, lat);
    chk("b2b_gap_len", 32'(lat), 32'd1);

    // abort during data bit 3 of 0xC3 (bit value 0)
    @(negedge clk);
    set_cfg(4'd15, 2'b11, 2'b00, 1'b0, 8'hC3);
    tx_valid = 1'b1;
    t = 0;
    while (tx !== 1'b0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("abort_start", 32'(tx), 32'd0);
    tx_valid = 1'b0;
    repeat (4 * 108 + 50) @(negedge clk);
    chk("abort_bit3", 32'({tx, busy}), 32'b01);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_edge", 32'({tx, busy, tx_done}), 32'b100);
    bad = 1'b0;
    repeat (300) begin
      if (tx_done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    chk("abort_quiet", 32'(bad), 32'd0);
    enable = 1'b1;
    set_cfg(4'd15, 2'b11, 2'b00, 1'b0, 8'h96);
    tx_valid = 1'b1;
    check_frame("after_abort_96", 12'h32C, 10, 108, 1'b0, 8'h00, lat);

    // reset mid-frame
    @(negedge clk);
    set_cfg(4'd15, 2'b11, 2'b00, 1'b0, 8'h00);
    tx_valid = 1'b1;
    t = 0;
    while (tx !== 1'b0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    tx_valid = 1'b0;
    repeat (150) @(negedge clk);
    arst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid", 32'({tx, busy, tx_ready, tx_done}), 32'b1000);
    arst_n = 1'b1;
    bad = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    chk("rst_mid_quiet", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_peer_tx.md
Name: uart_peer_tx

Overview:
- Synthesizable UART frame transmitter acting as the far-end peer that drives the `rx` pin of `uart_ip`.
- Takes bytes over a valid/ready handshake and serialises them, LSB first, using the same configuration encoding as `uart_ip`: 16-entry baud table, 5–8 data bits, parity, 1/2 stop bits.
- Used in loopback/self-test builds and as a reusable transmit engine.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz; used to derive the baud divisors.
- IDLE_LEVEL, 1'b1, line level driven when idle or disabled.

Ports:
- clk  in  1  system clock
- arst_n  in  1  reset, synchronous, active-low
- enable  in  1  block enable; low forces IDLE
- baud_sel  in  4  index into BAUD_RATES {200,300,600,1200,1800,2400,4800,9600,19200,28800,38400,57600,76800,115200,230400,460800}
- frame_size  in  2  00=5, 01=6, 10=7, 11=8 data bits
- parity_type  in  2  00=none, 01=even, 10=odd, 11=none
- stop_type  in  1  0=one stop bit, 1=two stop bits
- tx_data  in  8  byte to send; bits above the frame size are ignored
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  block can accept a byte
- tx  out  1  serial line, registered
- busy  out  1  a frame is in progress
- tx_done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (arst_n low at a clk edge):
  - Outputs: tx=IDLE_LEVEL, busy=0, tx_ready=0, tx_done=0.
  - State=IDLE; all counters cleared.
  - Reset asserted mid-frame aborts the frame with no tx_done.
- tx_ready = (state==IDLE) && enable && !tx_done, combinational from registers.
- Handshake: accept occurs on a clk edge with tx_valid && tx_ready.
  - At accept, latch tx_data, frame_size, parity_type, stop_type and divisor DIV = CLK_FREQ / BAUD_RATES[baud_sel] (integer truncation).
  - Config changes during a frame have no effect on that frame.
- State machine: IDLE → START → DATA → PARITY → STOP1 → STOP2 → IDLE.
  - START: tx=0 for DIV cycles. tx goes low the cycle after accept.
  - DATA: bit_idx 0..N-1, tx=data[bit_idx], DIV cycles per bit, LSB first.
  - PARITY: entered only when parity_type is 01 or 10. Even: tx = ^data[N-1:0]. Odd: tx = ~^data[N-1:0]. Lasts DIV cycles.
  - STOP1: tx=1 for DIV cycles.
  - STOP2: entered only when stop_type=1; tx=1 for DIV cycles.
- Baud counter: counts 0..DIV-1 and advances the bit on terminal count. Width is clog2 of the largest divisor (CLK_FREQ/200).
- Frame length is exactly DIV*(1+N+P+S) cycles from the first low cycle to the last stop cycle.
- Frame end:
  - tx_done pulses for 1 cycle on the edge leaving the last stop bit; state=IDLE the same edge, busy falls the same edge.
  - tx_ready stays low in the tx_done cycle, so there is a minimum one-cycle idle gap between frames.
- busy = (state != IDLE).
- enable deasserted:
  - In IDLE: no accept.
  - Mid-frame: abort on the next edge — state=IDLE, tx=IDLE_LEVEL, no tx_done.
- tx_valid held with stable data across tx_ready low is legal; tx_data may change freely while tx_valid is low.
- baud_sel values 0..15 are all legal; no divisor-zero case exists at the default CLK_FREQ.

Decomposition:
- Package `uart_pkg` holds:
  - the BAUD_RATES table
  - state enum `tnsm_state_t` with encodings IDLE=000, START=001, DATA=010, PARITY=011, STOP1=100, STOP2=101
  - parity and frame-size encodings
  - function `baud_div(clk_freq, sel)`
- One natural sub-module: `uart_baud_tick`, a divisor-load counter producing `bit_tick`, restartable on accept.

Test Plan:
- Basic 8N1 frame:
  - Stimulus: baud_sel=7 (DIV=5208), frame_size=11, parity=00, stop=0, tx_data=8'hA5.
  - Response: tx low 5208 cycles, then bits 1,0,1,0,0,1,0,1, then high; tx_done at cycle 52080 after first low.
- 5-bit even parity, two stop bits:
  - Stimulus: baud_sel=15 (DIV=108), frame_size=00, parity=01, stop=1, tx_data=8'hFF.
  - Response: data 11111, parity=1, two stop bits; total 972 cycles; upper 3 bits are never sent.
- 7-bit odd parity:
  - Stimulus: baud_sel=13 (DIV=434), frame_size=10, parity=10, tx_data=8'h00.
  - Response: parity bit=1; total 10*434 cycles.
- Back-to-back frames with tx_valid held high:
  - Stimulus: tx_data 8'h55 then 8'h0F, DIV=108.
  - Response: exactly one idle-high cycle between frames; tx_ready low while busy.
- Mid-frame abort:
  - Stimulus: enable dropped during DATA bit 3.
  - Response: next edge tx=1, busy=0, no tx_done. A following byte sends a correct full frame.
- Loopback to `uart_ip`:
  - Stimulus: tx wired to rx with matching config, 50 random bytes/configs.
  - Response: every received `data` equals the sent byte masked to the frame size.
